// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Shares one DDRAM write port among NCORES pixel producers. Cores are
//   granted round-robin. Each granted pixel (x, y, RGB565) becomes a
//   single-beat 64-bit write with byte enables. Pixels outside the visible
//   area are still accepted from the core, but they are discarded and counted.
//   A clear request fills the visible framebuffer with zeros, one word per
//   accepted write.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | arbitrating core requests, one grant per free write slot
//   CLEAR  | streaming zero words over the visible frame, no grants
//
// Ports
//   clk, reset_n               clock, async active-low reset
//   req_valid/x/y/pixel        per-core pixel offer (11/11/16 bits per core)
//   req_ready                  one-hot pulse: that core's pixel was taken
//   core_enable                0 = core is paused and never granted
//   clear / clear_busy         start a frame clear / clear in progress
//   ddram_*                    single-beat write port (read tied off)
//   dropped                    saturating count of discarded pixels
module fb_write_arbiter #(
  parameter int          NCORES  = 20,
  parameter logic [31:0] FB_BASE = 32'h20000000,
  parameter int          STRIDE  = 4096,
  parameter int          WIDTH   = 1920,
  parameter int          HEIGHT  = 1080
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [NCORES*11-1:0] req_x,
  input  logic [NCORES*11-1:0] req_y,
  input  logic [NCORES*16-1:0] req_pixel,
  output logic [NCORES-1:0]    req_ready,
  input  logic [NCORES-1:0]    core_enable,
  input  logic                 clear,
  output logic                 clear_busy,
  input  logic                 ddram_busy,
  output logic [28:0]          ddram_addr,
  output logic [63:0]          ddram_din,
  output logic [7:0]           ddram_be,
  output logic                 ddram_we,
  output logic                 ddram_rd,
  output logic [7:0]           ddram_burstcnt,
  output logic [15:0]          dropped
);

  localparam int          PTR_W    = $clog2(NCORES);
  localparam int          WORDS    = WIDTH / 4;
  localparam logic [31:0] STRIDE_U = 32'(STRIDE);
  localparam logic [31:0] WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_U = 32'(HEIGHT);
  localparam logic [15:0] LAST_Y   = 16'(HEIGHT - 1);
  localparam logic [15:0] LAST_W   = 16'(WORDS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t state, state_nxt;

  // single-entry output register
  logic        out_full;
  logic [28:0] out_addr;
  logic [63:0] out_din;
  logic [7:0]  out_be;

  logic        accept;
  logic        slot_free;
  logic        grant_en;
  logic        grant;
  logic        clr_load;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;

  logic [10:0] xs   [NCORES];
  logic [10:0] ys   [NCORES];
  logic [15:0] pixs [NCORES];

  logic [10:0] sel_x;
  logic [10:0] sel_y;
  logic [15:0] sel_pix;
  logic        in_range;
  logic [31:0] pix_byte;
  logic [28:0] pix_word;
  logic [7:0]  pix_be;

  logic [15:0] clr_y;
  logic [15:0] clr_w;
  logic        clr_issued;
  logic        clr_last;
  logic [31:0] clr_byte;
  logic [28:0] clr_word;

  assign accept    = out_full && !ddram_busy;
  // the slot frees on the same edge its write is accepted
  assign slot_free = !out_full || accept;

  for (genvar i = 0; i < NCORES; i++) begin : g_unpack
    assign xs[i]   = req_x[11*i +: 11];
    assign ys[i]   = req_y[11*i +: 11];
    assign pixs[i] = req_pixel[16*i +: 16];
  end

  // round-robin search starting at rr_ptr, wrapping at NCORES-1
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      cand = PTR_W'(idx);
      if (!gnt_found && req_valid[cand] && core_enable[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant = grant_en && gnt_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_x    = xs[gnt_idx];
  assign sel_y    = ys[gnt_idx];
  assign sel_pix  = pixs[gnt_idx];
  assign in_range = ({21'b0, sel_x} < WIDTH_U) && ({21'b0, sel_y} < HEIGHT_U);
  assign pix_byte = FB_BASE + {21'b0, sel_y} * STRIDE_U + {20'b0, sel_x, 1'b0};
  assign pix_word = 29'(pix_byte >> 3);
  assign pix_be   = 8'b11 << {sel_x[1:0], 1'b0};

  assign clr_byte = FB_BASE + {16'b0, clr_y} * STRIDE_U + {13'b0, clr_w, 3'b0};
  assign clr_word = 29'(clr_byte >> 3);
  assign clr_last = (clr_y == LAST_Y) && (clr_w == LAST_W);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clear) state_nxt = S_CLEAR;
      // clr_issued means the last clear word is the entry now held, so its
      // acceptance ends the clear
      S_CLEAR: if (accept && clr_issued) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clear_busy = (state == S_CLEAR);
    grant_en   = (state == S_IDLE) && !clear && slot_free;
    clr_load   = (state == S_CLEAR) && !clr_issued && slot_free;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_full <= 1'b0;
      out_addr <= '0;
      out_din  <= '0;
      out_be   <= '0;
    end else if (grant && in_range) begin
      out_full <= 1'b1;
      out_addr <= pix_word;
      out_din  <= {4{sel_pix}};
      out_be   <= pix_be;
    end else if (clr_load) begin
      out_full <= 1'b1;
      out_addr <= clr_word;
      out_din  <= '0;
      out_be   <= 8'hFF;
    end else if (accept) begin
      out_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= '0;
      dropped <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_idx == PTR_W'(NCORES - 1)) ? '0 : gnt_idx + 1'b1;
      if (!in_range && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_y      <= '0;
      clr_w      <= '0;
      clr_issued <= 1'b0;
    end else if (state == S_IDLE && state_nxt == S_CLEAR) begin
      clr_y      <= '0;
      clr_w      <= '0;
      clr_issued <= 1'b0;
    end else if (clr_load) begin
      if (clr_last) begin
        clr_issued <= 1'b1;
      end else if (clr_w == LAST_W) begin
        clr_w <= '0;
        clr_y <= clr_y + 16'd1;
      end else begin
        clr_w <= clr_w + 16'd1;
      end
    end
  end

  assign ddram_we       = out_full;
  assign ddram_addr     = out_addr;
  assign ddram_din      = out_din;
  assign ddram_be       = out_be;
  assign ddram_rd       = 1'b0;
  assign ddram_burstcnt = 8'd1;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter. The visible area is reduced to 64x8 so that a
// full frame clear fits in a short run; stride and base keep their defaults.
module tb_fb_write_arbiter;

  localparam int          N    = 20;
  localparam int          W    = 64;
  localparam int          H    = 8;
  localparam int          STR  = 4096;
  localparam logic [31:0] BASE = 32'h20000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid;
  logic [N-1:0]    enable;
  logic [N-1:0]    ready;
  logic [10:0]     cx [N];
  logic [10:0]     cy [N];
  logic [15:0]     cpix [N];
  bit              oneshot [N];
  logic [N*11-1:0] req_x;
  logic [N*11-1:0] req_y;
  logic [N*16-1:0] req_pixel;
  logic            clear;
  logic            clear_busy;
  logic            ddram_busy;
  logic [28:0]     ddram_addr;
  logic [63:0]     ddram_din;
  logic [7:0]      ddram_be;
  logic            ddram_we;
  logic            ddram_rd;
  logic [7:0]      ddram_burstcnt;
  logic [15:0]     dropped;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_x[11*i +: 11]     = cx[i];
    assign req_y[11*i +: 11]     = cy[i];
    assign req_pixel[16*i +: 16] = cpix[i];
  end

  fb_write_arbiter #(.NCORES(N), .FB_BASE(BASE), .STRIDE(STR), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(valid), .req_x(req_x), .req_y(req_y), .req_pixel(req_pixel),
    .req_ready(ready), .core_enable(enable),
    .clear(clear), .clear_busy(clear_busy),
    .ddram_busy(ddram_busy), .ddram_addr(ddram_addr), .ddram_din(ddram_din),
    .ddram_be(ddram_be), .ddram_we(ddram_we), .ddram_rd(ddram_rd),
    .ddram_burstcnt(ddram_burstcnt), .dropped(dropped)
  );

  typedef struct {logic [28:0] a; logic [63:0] d; logic [7:0] b;} wr_t;
  typedef struct {int core; bit wr;} gr_t;

  wr_t exp_wr[$];
  gr_t exp_gr[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_acc_clr = 0;

  logic [N-1:0] taken = '0;
  bit           chk_we = 0;
  bit           chk_no_we = 0;
  bit           prev_stall = 0;
  logic [28:0]  pa;
  logic [63:0]  pd;
  logic [7:0]   pb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk_wr(input int x, input int y, input logic [15:0] p);
    wr_t         r;
    logic [31:0] b;
    b   = BASE + 32'(y) * 32'(STR) + 32'(x) * 32'd2;
    r.a = b[31:3];
    r.d = {4{p}};
    r.b = 8'b11 << (2 * (x % 4));
    return r;
  endfunction

  function automatic wr_t mk_clr(input int y, input int w);
    wr_t         r;
    logic [31:0] b;
    b   = BASE + 32'(y) * 32'(STR) + 32'(w) * 32'd8;
    r.a = b[31:3];
    r.d = '0;
    r.b = 8'hFF;
    return r;
  endfunction

  // monitor: pops expected grants and writes whenever the DUT presents them
  always @(negedge clk) begin
    gr_t          g;
    wr_t          e;
    logic [N-1:0] oh;
    if (!reset_n) begin
      taken      = '0;
      chk_we     = 0;
      chk_no_we  = 0;
      prev_stall = 0;
    end else begin
      if (chk_we)    check("latency_we", 64'(ddram_we), 64'd1);
      if (chk_no_we) check("drop_no_we", 64'(ddram_we), 64'd0);
      chk_we    = 0;
      chk_no_we = 0;
      taken     = ready;
      if (ready != '0) begin
        if (exp_gr.size() == 0) begin
          check("unexpected_grant", 64'(ready), 64'd0);
        end else begin
          g  = exp_gr.pop_front();
          oh = '0;
          oh[g.core] = 1'b1;
          check("grant", 64'(ready), 64'(oh));
          chk_we    = g.wr;
          chk_no_we = !g.wr;
        end
      end
      if (ddram_we && ddram_busy) begin
        if (prev_stall) begin
          check("stall_addr", 64'(ddram_addr), 64'(pa));
          check("stall_din", ddram_din, pd);
          check("stall_be", 64'(ddram_be), 64'(pb));
        end
        prev_stall = 1;
        pa = ddram_addr;
        pd = ddram_din;
        pb = ddram_be;
      end else begin
        prev_stall = 0;
      end
      if (ddram_we && !ddram_busy) begin
        n_acc++;
        if (clear_busy) n_acc_clr++;
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(ddram_we), 64'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(ddram_addr), 64'(e.a));
          check("wr_din", ddram_din, e.d);
          check("wr_be", 64'(ddram_be), 64'(e.b));
        end
      end
    end
  end

  // one clock; one-shot cores withdraw once their pixel has been taken
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (taken[i] && oneshot[i]) valid[i] = 1'b0;
  endtask

  task automatic set_core(input int i, input int x, input int y, input logic [15:0] p, input bit os);
    cx[i]      = 11'(x);
    cy[i]      = 11'(y);
    cpix[i]    = p;
    oneshot[i] = os;
    valid[i]   = 1'b1;
  endtask

  task automatic push_px(input int i, input int x, input int y, input logic [15:0] p, input bit wr);
    gr_t g;
    g.core = i;
    g.wr   = wr;
    exp_gr.push_back(g);
    if (wr) exp_wr.push_back(mk_wr(x, y, p));
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    valid      = '0;
    enable     = '1;
    clear      = 1'b0;
    ddram_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      cx[i] = '0; cy[i] = '0; cpix[i] = '0; oneshot[i] = 0;
    end
    exp_gr.delete();
    exp_wr.delete();
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  acc0;
    wr_t w;

    do_reset();
    // reset state
    check("rst_we", 64'(ddram_we), 64'd0);
    check("rst_rd", 64'(ddram_rd), 64'd0);
    check("rst_burstcnt", 64'(ddram_burstcnt), 64'd1);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_clear_busy", 64'(clear_busy), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    check("rst_addr", 64'(ddram_addr), 64'd0);
    check("rst_be", 64'(ddram_be), 64'd0);
    check("rst_din", ddram_din, 64'd0);

    // all cores valid continuously: 0..19 twice, one grant per cycle
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_px(i, i * 3, i % H, 16'h1000 + 16'(i), 1);
    for (int i = 0; i < N; i++) set_core(i, i * 3, i % H, 16'h1000 + 16'(i), 0);
    acc0 = n_acc;
    n = 0;
    while (exp_gr.size() > 0 && n < 100) begin cycle(); n++; end
    valid = '0;
    check("rr_cycles", 64'(n), 64'd40);
    repeat (3) cycle();
    check("rr_writes", 64'(n_acc - acc0), 64'd40);

    // single core 3, x=5 y=1
    gr_t_push3: begin
      gr_t g;
      g.core = 3; g.wr = 1;
      exp_gr.push_back(g);
      w.a = 29'h04000201; w.d = 64'hF800F800F800F800; w.b = 8'h0C;
      exp_wr.push_back(w);
    end
    set_core(3, 5, 1, 16'hF800, 1);
    repeat (4) cycle();
    check("t1_drain", 64'(exp_gr.size() + exp_wr.size()), 64'd0);

    // core 1 paused: only core 0 is ever granted
    enable[1] = 1'b0;
    for (int k = 0; k < 5; k++) push_px(0, 8, 3, 16'h00FF, 1);
    set_core(1, 10, 2, 16'h0F0F, 0);
    set_core(0, 8, 3, 16'h00FF, 0);
    n = 0;
    while (exp_gr.size() > 0 && n < 50) begin cycle(); n++; end
    valid[0] = 1'b0;
    check("t3_grants_done", 64'(exp_gr.size()), 64'd0);
    repeat (10) cycle();
    check("t3_core1_ready", 64'(ready[1]), 64'd0);
    valid[1]  = 1'b0;
    enable[1] = 1'b1;
    repeat (2) cycle();

    // busy stall with a pending write, then release: accept + grant same edge
    ddram_busy = 1'b1;
    push_px(2, 12, 4, 16'hAAAA, 1);
    set_core(2, 12, 4, 16'hAAAA, 1);
    repeat (2) cycle();
    set_core(5, 20, 5, 16'h5555, 1);
    repeat (10) cycle();
    check("t4_we_held", 64'(ddram_we), 64'd1);
    check("t4_no_grant", 64'(exp_gr.size()), 64'd0);
    push_px(5, 20, 5, 16'h5555, 1);
    ddram_busy = 1'b0;
    @(negedge clk);
    check("t4_same_edge_ready", 64'(ready), 64'd1 << 5);
    check("t4_same_edge_we", 64'(ddram_we), 64'd1);
    cycle();
    repeat (3) cycle();
    check("t4_drain", 64'(exp_gr.size() + exp_wr.size()), 64'd0);

    // out-of-range drops and the last visible pixel
    push_px(0, W, 0, 16'h1234, 0);
    set_core(0, W, 0, 16'h1234, 1);
    repeat (3) cycle();
    check("t5_dropped1", 64'(dropped), 64'd1);
    gr_t_push_last: begin
      gr_t g;
      g.core = 1; g.wr = 1;
      exp_gr.push_back(g);
      w.a = 29'h04000E0F; w.d = {4{16'hBEEF}}; w.b = 8'hC0;
      exp_wr.push_back(w);
    end
    set_core(1, W - 1, H - 1, 16'hBEEF, 1);
    repeat (3) cycle();
    check("t5_dropped_hold", 64'(dropped), 64'd1);
    push_px(2, 0, H, 16'h4321, 0);
    set_core(2, 0, H, 16'h4321, 1);
    repeat (3) cycle();
    check("t5_dropped2", 64'(dropped), 64'd2);

    // frame clear with a pending pixel written first; clear beats a request
    ddram_busy = 1'b1;
    push_px(6, 4, 1, 16'h7777, 1);
    set_core(6, 4, 1, 16'h7777, 1);
    repeat (2) cycle();
    for (int y = 0; y < H; y++)
      for (int wd = 0; wd < W / 4; wd++) exp_wr.push_back(mk_clr(y, wd));
    push_px(4, 1, 1, 16'h4444, 1);
    acc0       = n_acc_clr;
    clear      = 1'b1;
    ddram_busy = 1'b0;
    set_core(4, 1, 1, 16'h4444, 1);
    cycle();
    clear = 1'b0;
    check("t6_clear_busy", 64'(clear_busy), 64'd1);
    repeat (5) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    n = 0;
    while (clear_busy && n < 1000) begin cycle(); n++; end
    check("t6_clear_done", 64'(clear_busy), 64'd0);
    check("t6_clear_writes", 64'(n_acc_clr - acc0), 64'(H * W / 4));
    repeat (4) cycle();
    check("t6_drain", 64'(exp_gr.size() + exp_wr.size()), 64'd0);

    // reset in the middle of a clear
    for (int y = 0; y < H; y++)
      for (int wd = 0; wd < W / 4; wd++) exp_wr.push_back(mk_clr(y, wd));
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (20) cycle();
    check("t7_busy_before", 64'(clear_busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t7_we_async", 64'(ddram_we), 64'd0);
    check("t7_clear_busy_async", 64'(clear_busy), 64'd0);
    exp_wr.delete();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (3) cycle();
    check("t7_we_after", 64'(ddram_we), 64'd0);
    check("t7_idle_after", 64'(clear_busy), 64'd0);
    check("final_drain", 64'(exp_gr.size() + exp_wr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
